// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared types and constants for the 5-stage pipeline control
// logic.
//   XLEN, REG_W   : PC/target width and register-address width
//   ctrl_state_t  : hazard controller FSM state (RUN, MEM_WAIT, REDIRECT)
//   ctrl_out_t    : bundle of the pipeline-register control outputs
//   load_use()    : load-use hazard detector
package riscv_pipe_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic            pc_we;
        logic            ifid_we;
        logic            idex_we;
        logic            exmem_we;
        logic            ifid_flush;
        logic            idex_flush;
        logic            pc_redirect;
        logic [XLEN-1:0] redirect_pc;
    } ctrl_out_t;

    // A load in EX whose destination is read by the instruction in ID.
    // x0 is never a real destination, so it never stalls.
    function automatic logic load_use(
        input logic             ex_valid,
        input logic             ex_mem_read,
        input logic [REG_W-1:0] ex_rd,
        input logic             id_valid,
        input logic             id_use_rs1,
        input logic [REG_W-1:0] id_rs1,
        input logic             id_use_rs2,
        input logic [REG_W-1:0] id_rs2
    );
        return ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard-status inputs and pipeline-register controls
// exchanged between the datapath and the hazard controller.
//   master : datapath side (drives hazard status, receives controls)
//   slave  : hazard controller side
interface hazard_ctrl_if;
    import riscv_pipe_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_valid;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_redirect;
    logic [XLEN-1:0]  ex_target;
    logic             mem_busy;

    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pc_redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [1:0]       ctrl_state;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_valid, ex_mem_read, ex_rd, ex_redirect, ex_target, mem_busy,
        input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
               pc_redirect, redirect_pc, ctrl_state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_valid, ex_mem_read, ex_rd, ex_redirect, ex_target, mem_busy,
        output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
               pc_redirect, redirect_pc, ctrl_state
    );

endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: saturating performance counters for the hazard controller.
//   clk, reset    : core clock, asynchronous active-high reset
//   pc_we         : PC load enable; a cycle with it low is a stall cycle
//   ifid_flush    : IF/ID squash; each cycle with it high is a flush event
//   stall_cycles  : saturating count of stall cycles
//   flush_events  : saturating count of flush cycles
// Counters are held at 0 while reset is asserted, so the reset-time
// flush indication is not counted.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_we,
    input  logic        ifid_flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_we && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (ifid_flush && (flush_events != '1))
                flush_events <= flush_events + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RV64 core.
// Decides each cycle whether PC, IF/ID, ID/EX and EX/MEM load, hold or are
// squashed, for load-use hazards, EX-resolved redirects and data-memory waits.
// A redirect seen while memory is busy is latched and replayed afterwards.
//   clk, reset : core clock, asynchronous active-high reset
//   bus        : hazard_ctrl_if.slave (hazard status in, controls out)
//   stall_cycles, flush_events : perf counters, only with HAZARD_PERF_EN
// Optional feature macro: HAZARD_PERF_EN.
// All outputs are Mealy: combinational from state, pending redirect and inputs.
module hazard_ctrl
    import riscv_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  flush_events
`endif
);

    ctrl_state_t     state, state_nxt;
    logic            pending;
    logic [XLEN-1:0] pend_pc;
    logic            lu;
    ctrl_out_t       run_o;
    ctrl_out_t       o;

    assign lu = load_use(bus.ex_valid, bus.ex_mem_read, bus.ex_rd, bus.id_valid,
                         bus.id_use_rs1, bus.id_rs1, bus.id_use_rs2, bus.id_rs2);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Deferred redirect: captured when memory stalls a redirecting EX
    // instruction, consumed by the REDIRECT state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            pend_pc <= '0;
        end else if ((state == RUN) && bus.mem_busy && bus.ex_redirect) begin
            pending <= 1'b1;
            pend_pc <= bus.ex_target;
        end else if (state == REDIRECT) begin
            pending <= 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      state_nxt = bus.mem_busy ? MEM_WAIT : RUN;
            MEM_WAIT: begin
                if (!bus.mem_busy)
                    state_nxt = pending ? REDIRECT : RUN;
            end
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Normal-run evaluation; also used on the MEM_WAIT exit cycle when no
    // redirect is pending, so a load-use still present there is honoured.
    always_comb begin
        run_o = '0;
        if (bus.mem_busy) begin
            run_o = '0;
        end else if (bus.ex_redirect) begin
            // The redirect squashes the ID instruction, so any stall is moot.
            run_o.pc_we       = 1'b1;
            run_o.ifid_we     = 1'b1;
            run_o.idex_we     = 1'b1;
            run_o.exmem_we    = 1'b1;
            run_o.ifid_flush  = 1'b1;
            run_o.idex_flush  = 1'b1;
            run_o.pc_redirect = 1'b1;
            run_o.redirect_pc = bus.ex_target;
        end else if (lu) begin
            // Hold PC and IF/ID, push a bubble into ID/EX.
            run_o.idex_we     = 1'b1;
            run_o.exmem_we    = 1'b1;
            run_o.idex_flush  = 1'b1;
        end else begin
            run_o.pc_we       = 1'b1;
            run_o.ifid_we     = 1'b1;
            run_o.idex_we     = 1'b1;
            run_o.exmem_we    = 1'b1;
        end
    end

    // Output logic
    always_comb begin
        o = '0;
        if (reset) begin
            o.ifid_flush = 1'b1;
            o.idex_flush = 1'b1;
        end else begin
            case (state)
                RUN:      o = run_o;
                MEM_WAIT: begin
                    // Frozen while busy; the exit cycle toward REDIRECT
                    // also keeps everything held.
                    if (!bus.mem_busy && !pending)
                        o = run_o;
                end
                REDIRECT: begin
                    o.pc_we       = 1'b1;
                    o.idex_we     = 1'b1;
                    o.exmem_we    = 1'b1;
                    o.ifid_flush  = 1'b1;
                    o.idex_flush  = 1'b1;
                    o.pc_redirect = 1'b1;
                    o.redirect_pc = pend_pc;
                end
                default:  o = '0;
            endcase
        end
    end

    assign bus.pc_we       = o.pc_we;
    assign bus.ifid_we     = o.ifid_we;
    assign bus.idex_we     = o.idex_we;
    assign bus.exmem_we    = o.exmem_we;
    assign bus.ifid_flush  = o.ifid_flush;
    assign bus.idex_flush  = o.idex_flush;
    assign bus.pc_redirect = o.pc_redirect;
    assign bus.redirect_pc = o.redirect_pc;
    assign bus.ctrl_state  = state;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf (
        .clk          (clk),
        .reset        (reset),
        .pc_we        (o.pc_we),
        .ifid_flush   (o.ifid_flush),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven directed bench for hazard_ctrl, plus
// hand-written sequences for reset behaviour.
// Optional feature macro: HAZARD_PERF_EN (perf counter checks).
module tb_hazard_ctrl;
    import riscv_pipe_pkg::*;

    logic clk;
    logic reset;
    hazard_ctrl_if bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             idv;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             u1;
        logic             u2;
        logic             exv;
        logic             mr;
        logic [REG_W-1:0] rd;
        logic             redir;
        logic [XLEN-1:0]  target;
        logic             busy;
        logic [3:0]       we;   // {pc, ifid, idex, exmem}
        logic [1:0]       fl;   // {ifid, idex}
        logic             pcr;
        logic [XLEN-1:0]  rpc;
        logic [1:0]       st;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;

    function automatic vec_t mk(
        input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2, input logic exv, input logic mr,
        input logic [4:0] rd, input logic redir, input logic [63:0] target,
        input logic busy, input logic [3:0] we, input logic [1:0] fl,
        input logic pcr, input logic [63:0] rpc, input logic [1:0] st);
        vec_t v;
        v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exv = exv; v.mr = mr; v.rd = rd; v.redir = redir; v.target = target;
        v.busy = busy; v.we = we; v.fl = fl; v.pcr = pcr; v.rpc = rpc; v.st = st;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.id_valid    = v.idv;
        bus.id_rs1      = v.rs1;
        bus.id_rs2      = v.rs2;
        bus.id_use_rs1  = v.u1;
        bus.id_use_rs2  = v.u2;
        bus.ex_valid    = v.exv;
        bus.ex_mem_read = v.mr;
        bus.ex_rd       = v.rd;
        bus.ex_redirect = v.redir;
        bus.ex_target   = v.target;
        bus.mem_busy    = v.busy;
    endtask

    // Compare {we, flushes, pc_redirect, redirect_pc, ctrl_state}.
    task automatic check_out(input string name, input vec_t v);
        logic [72:0] act, exp;
        act = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we,
               bus.ifid_flush, bus.idex_flush, bus.pc_redirect,
               bus.redirect_pc, bus.ctrl_state};
        exp = {v.we, v.fl, v.pcr, v.rpc, v.st};
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got we=%b fl=%b pcr=%b rpc=%h st=%0d, want we=%b fl=%b pcr=%b rpc=%h st=%0d",
                      name, act[72:69], act[68:67], act[66], act[65:2], act[1:0],
                      v.we, v.fl, v.pcr, v.rpc, v.st);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    vec_t nrm;   // hazard-free instruction pair, no redirect, memory ready
    vec_t v;

    initial begin
        int exp_stall;
        int exp_flush;
        nrm = mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 64'h0, 0, 4'b1111, 2'b00, 0, 64'h0, 0);

        //        idv rs1 rs2 u1 u2 exv mr rd redir target  busy we      fl     pcr rpc      st
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 64'h0,    0, 4'b1111, 2'b00, 0, 64'h0,    0)); // plain run
        vecs.push_back(mk(1, 5, 2, 1, 1, 1, 1, 5, 0, 64'h0,    0, 4'b0011, 2'b01, 0, 64'h0,    0)); // load-use rs1
        vecs.push_back(mk(1, 5, 2, 1, 1, 1, 0, 3, 0, 64'h0,    0, 4'b1111, 2'b00, 0, 64'h0,    0)); // after bubble
        vecs.push_back(mk(1, 0, 2, 1, 1, 1, 1, 0, 0, 64'h0,    0, 4'b1111, 2'b00, 0, 64'h0,    0)); // rd=0 no stall
        vecs.push_back(mk(1, 3, 7, 1, 1, 1, 1, 7, 0, 64'h0,    0, 4'b0011, 2'b01, 0, 64'h0,    0)); // load-use rs2
        vecs.push_back(mk(1, 3, 7, 1, 0, 1, 1, 7, 0, 64'h0,    0, 4'b1111, 2'b00, 0, 64'h0,    0)); // rs2 unused
        vecs.push_back(mk(0, 5, 2, 1, 1, 1, 1, 5, 0, 64'h0,    0, 4'b1111, 2'b00, 0, 64'h0,    0)); // ID invalid
        vecs.push_back(mk(1, 5, 2, 1, 1, 0, 1, 5, 0, 64'h0,    0, 4'b1111, 2'b00, 0, 64'h0,    0)); // EX invalid
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 1, 64'h1000, 0, 4'b1111, 2'b11, 1, 64'h1000, 0)); // taken branch
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 64'h1000, 0, 4'b1111, 2'b00, 0, 64'h0,    0)); // one cycle only
        vecs.push_back(mk(1, 5, 2, 1, 1, 1, 1, 5, 1, 64'h3000, 0, 4'b1111, 2'b11, 1, 64'h3000, 0)); // redirect beats lu
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 1, 64'h2040, 1, 4'b0000, 2'b00, 0, 64'h0,    0)); // busy+redirect
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 64'h0,    1, 4'b0000, 2'b00, 0, 64'h0,    1)); // wait
        vecs.push_back(mk(1, 5, 2, 1, 1, 1, 1, 5, 1, 64'hdead, 1, 4'b0000, 2'b00, 0, 64'h0,    1)); // wait, ignore
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 64'h0,    0, 4'b0000, 2'b00, 0, 64'h0,    1)); // busy drops
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 64'h0,    0, 4'b1011, 2'b11, 1, 64'h2040, 2)); // replay
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 64'h0,    0, 4'b1111, 2'b00, 0, 64'h0,    0)); // back to run
        vecs.push_back(mk(1, 5, 2, 1, 1, 1, 1, 5, 0, 64'h0,    1, 4'b0000, 2'b00, 0, 64'h0,    0)); // busy beats lu
        vecs.push_back(mk(1, 5, 2, 1, 1, 1, 1, 5, 0, 64'h0,    1, 4'b0000, 2'b00, 0, 64'h0,    1)); // wait
        vecs.push_back(mk(1, 5, 2, 1, 1, 1, 1, 5, 0, 64'h0,    0, 4'b0011, 2'b01, 0, 64'h0,    1)); // exit with lu
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 64'h0,    0, 4'b1111, 2'b00, 0, 64'h0,    0)); // run

        // Reset held: outputs forced to the squash/hold pattern.
        reset = 1'b1;
        drive(nrm);
        @(negedge clk);
        v = nrm; v.we = 4'b0000; v.fl = 2'b11;
        check_out("reset_held", v);
`ifdef HAZARD_PERF_EN
        check32("perf_stall_reset", stall_cycles, 32'd0);
        check32("perf_flush_reset", flush_events, 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;

        exp_stall = 0;
        exp_flush = 0;
        foreach (vecs[i]) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            drive(vecs[i]);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i]);
            if (!vecs[i].we[3]) exp_stall++;
            if (vecs[i].fl[1])  exp_flush++;
        end

        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        check32("perf_stall", stall_cycles, exp_stall);
        check32("perf_flush", flush_events, exp_flush);
`endif

        // Reset while in MEM_WAIT with a redirect pending.
        v = nrm; v.redir = 1'b1; v.target = 64'h4000; v.busy = 1'b1;
        drive(v);
        @(negedge clk);
        v.we = 4'b0000; v.st = 2'd0;
        check_out("rst_seq_enter", v);
        @(posedge clk);
        #1;
        v = nrm; v.busy = 1'b1;
        drive(v);
        @(negedge clk);
        v.we = 4'b0000; v.st = 2'd1;
        check_out("rst_seq_wait", v);
        #2 reset = 1'b1;
        #1;
        v.fl = 2'b11; v.st = 2'd0;
        check_out("rst_async", v);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(nrm);
        @(negedge clk);
        check_out("rst_release", nrm);
        // A fresh wait without a redirect must exit straight to RUN; a
        // surviving pending redirect would hold here and replay 0x4000.
        @(posedge clk);
        #1;
        v = nrm; v.busy = 1'b1;
        drive(v);
        @(negedge clk);
        v.we = 4'b0000;
        check_out("rst_post_busy", v);
        @(posedge clk);
        #1;
        drive(nrm);
        @(negedge clk);
        v = nrm; v.st = 2'd1;
        check_out("rst_post_exit", v);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_out("rst_post_run", nrm);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
